// File: rtl/pet_state_ctrl_if.sv
// Button inputs and pet status outputs of the pet state controller.
interface pet_state_ctrl_if;
    logic       senal_test;
    logic       senal_energia;
    logic       senal_medicina;
    logic [2:0] energia;
    logic [2:0] salud;
    logic [1:0] modo;
    logic       ev_energia;
    logic       ev_medicina;
    logic       tick;

    modport master (
        output senal_test, senal_energia, senal_medicina,
        input  energia, salud, modo, ev_energia, ev_medicina, tick
    );

    modport slave (
        input  senal_test, senal_energia, senal_medicina,
        output energia, salud, modo, ev_energia, ev_medicina, tick
    );
endinterface

// File: rtl/pet_state_ctrl.sv
// Virtual pet core: synchronises toggle-coded buttons, generates game ticks,
// updates saturating energy/health levels and runs the NORMAL/TEST/MUERTO FSM.
module pet_state_ctrl #(
    parameter int TICK_DIV = 5,
    parameter int TEST_DIV = 2,
    parameter int MAX_LVL  = 7
) (
    input  logic            clk,
    input  logic            reset_tmp,
    pet_state_ctrl_if.slave bus
);
    localparam int DIV_MAX = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
    localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic signed [4:0] MAX_S = 5'(MAX_LVL);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        TEST   = 2'b01,
        MUERTO = 2'b10
    } mode_t;

    // Bit 0 = test, bit 1 = feed, bit 2 = medicine.
    logic [2:0]       sync1_r, sync2_r, prev_r;
    logic [1:0]       sup_r;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, term_s;
    mode_t            mode_r, mode_next_s;
    logic [2:0]       energia_r, salud_r, e_next_s, s_next_s;
    logic             tick_r, ev_e_r, ev_m_r;

    logic [2:0]        acc_s;
    logic              alive_s, armed_s, test_p_s, feed_s, med_s, tick_s;
    logic signed [4:0] e_sum_s, s_sum_s;

    // Two-flop synchroniser plus a history flop per button; each level change is one press.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            prev_r  <= 3'b000;
        end else begin
            sync1_r <= {bus.senal_medicina, bus.senal_energia, bus.senal_test};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Blank presses for the first three edges after reset so stale levels never count.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            sup_r <= 2'd0;
        end else if (sup_r != 2'd3) begin
            sup_r <= sup_r + 2'd1;
        end
    end

    // Press acceptance, tick detection and saturating level arithmetic.
    always_comb begin
        alive_s  = (mode_r != MUERTO);
        armed_s  = (sup_r == 2'd3);
        acc_s    = (sync2_r ^ prev_r) & {3{armed_s & alive_s}};
        test_p_s = acc_s[0];
        feed_s   = acc_s[1];
        med_s    = acc_s[2];
        if (mode_r == TEST) begin
            term_s = CNT_W'(TEST_DIV - 1);
        end else begin
            term_s = CNT_W'(TICK_DIV - 1);
        end
        // A test press changes mode, which restarts the period instead of ticking.
        tick_s  = alive_s && (cnt_r >= term_s) && !test_p_s;
        e_sum_s = $signed({2'b00, energia_r})
                + (feed_s ? 5'sd2 : 5'sd0)
                - (tick_s ? 5'sd1 : 5'sd0);
        s_sum_s = $signed({2'b00, salud_r})
                + (med_s ? 5'sd1 : 5'sd0)
                - ((tick_s && (energia_r == 3'd0)) ? 5'sd1 : 5'sd0);
        if (!alive_s) begin
            e_next_s = energia_r;
        end else if (e_sum_s < 5'sd0) begin
            e_next_s = 3'd0;
        end else if (e_sum_s > MAX_S) begin
            e_next_s = MAX_S[2:0];
        end else begin
            e_next_s = e_sum_s[2:0];
        end
        if (!alive_s) begin
            s_next_s = salud_r;
        end else if (s_sum_s < 5'sd0) begin
            s_next_s = 3'd0;
        end else if (s_sum_s > MAX_S) begin
            s_next_s = MAX_S[2:0];
        end else begin
            s_next_s = s_sum_s[2:0];
        end
    end

    // Mode FSM next state and tick counter; death outranks a test press.
    always_comb begin
        mode_next_s = mode_r;
        cnt_next_s  = cnt_r;
        case (mode_r)
            NORMAL, TEST: begin
                if (s_next_s == 3'd0) begin
                    mode_next_s = MUERTO;
                    cnt_next_s  = '0;
                end else if (test_p_s) begin
                    mode_next_s = (mode_r == NORMAL) ? TEST : NORMAL;
                    cnt_next_s  = '0;
                end else if (tick_s) begin
                    cnt_next_s = '0;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            MUERTO: begin
                cnt_next_s = '0;
            end
            default: begin
                mode_next_s = MUERTO;
                cnt_next_s  = '0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            mode_r    <= NORMAL;
            cnt_r     <= '0;
            energia_r <= MAX_S[2:0];
            salud_r   <= MAX_S[2:0];
            tick_r    <= 1'b0;
            ev_e_r    <= 1'b0;
            ev_m_r    <= 1'b0;
        end else begin
            mode_r    <= mode_next_s;
            cnt_r     <= cnt_next_s;
            energia_r <= e_next_s;
            salud_r   <= s_next_s;
            tick_r    <= tick_s;
            ev_e_r    <= feed_s;
            ev_m_r    <= med_s;
        end
    end

    assign bus.energia     = energia_r;
    assign bus.salud       = salud_r;
    assign bus.modo        = mode_r;
    assign bus.tick        = tick_r;
    assign bus.ev_energia  = ev_e_r;
    assign bus.ev_medicina = ev_m_r;
endmodule
